// File: rtl/dcache_maint_pkg.sv
// Shared types for the dcache maintenance sequencer: walk modes, FSM states
// and the requester mode decode.
package dcache_maint_pkg;

  typedef enum logic [1:0] {
    MODE_WB_INV = 2'd0,
    MODE_CLEAN  = 2'd1,
    MODE_INV    = 2'd2
  } maint_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EVAL,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_WR,
    ST_ACK
  } maint_state_e;

  // Encoding 3 is reserved and behaves as WB_INV.
  function automatic maint_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_CLEAN;
      2'd2:    return MODE_INV;
      default: return MODE_WB_INV;
    endcase
  endfunction

endpackage

// File: rtl/dcache_maint_way_sel.sv
// Priority encoder over the pending-writeback mask: lowest set way wins.
module dcache_maint_way_sel
  import dcache_maint_pkg::*;
#(
  parameter int NUM_WAYS = 8,
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic [NUM_WAYS-1:0] pending,
  output logic [WAY_W-1:0]    way,
  output logic                empty
);

  always_comb begin
    way = '0;
    for (int unsigned i = NUM_WAYS; i > 0; i--) begin
      if (pending[i-1]) way = WAY_W'(i - 1);
    end
  end

  assign empty = ~|pending;

endmodule

// File: rtl/dcache_maint_ctrl.sv
// Dcache maintenance sequencer: arbitrates flush requests, walks every set of the
// valid/dirty SRAM, writes back dirty ways as the mode requires and acks the winners.
module dcache_maint_ctrl
  import dcache_maint_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [2*NUM_REQ-1:0] req_mode_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic                 flushing_o,
  output logic                 vld_req_o,
  input  logic                 vld_gnt_i,
  output logic                 vld_we_o,
  output logic [IDX_W-1:0]     vld_index_o,
  output logic [NUM_WAYS-1:0]  vld_wvalid_o,
  output logic [NUM_WAYS-1:0]  vld_wdirty_o,
  input  logic [NUM_WAYS-1:0]  vld_rvalid_i,
  input  logic [NUM_WAYS-1:0]  vld_rdirty_i,
  output logic                 wb_req_o,
  input  logic                 wb_gnt_i,
  output logic [WAY_W-1:0]     wb_way_o,
  input  logic                 wb_done_i
);

  maint_state_e        state_q, state_d;
  maint_mode_e         mode_q, mode_d, win_mode;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [NUM_WAYS-1:0] pending_q, pending_d, valid_q, valid_d, way_bit, pend_left;
  logic [NUM_REQ-1:0]  mask_q, mask_d, snap;
  logic [WAY_W-1:0]    first_way;
  logic                pend_empty, win_found;

  dcache_maint_way_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_way_sel (
    .pending (pending_q),
    .way     (first_way),
    .empty   (pend_empty)
  );

  assign way_bit   = NUM_WAYS'(1) << first_way;
  assign pend_left = pending_q & ~way_bit;

  // Lowest requester wins; every requester asking for the same decoded mode rides along.
  always_comb begin
    win_found = 1'b0;
    win_mode  = MODE_WB_INV;
    snap      = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req_i[i-1]) begin
        win_found = 1'b1;
        win_mode  = decode_mode(req_mode_i[2*(i-1) +: 2]);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      snap[i] = req_i[i] && (decode_mode(req_mode_i[2*i +: 2]) == win_mode);
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    index_d      = index_q;
    pending_d    = pending_q;
    valid_d      = valid_q;
    mask_d       = mask_q;
    ack_o        = '0;
    vld_req_o    = 1'b0;
    vld_we_o     = 1'b0;
    vld_wvalid_o = '0;
    vld_wdirty_o = '0;
    wb_req_o     = 1'b0;
    wb_way_o     = '0;
    flushing_o   = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          mode_d  = win_mode;
          mask_d  = snap;
          index_d = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        vld_req_o = 1'b1;
        if (vld_gnt_i) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        valid_d   = vld_rvalid_i;
        pending_d = (mode_q != MODE_INV) ? (vld_rvalid_i & vld_rdirty_i) : '0;
        state_d   = |pending_d ? ST_WB_REQ : ST_WR;
      end
      ST_WB_REQ: begin
        wb_req_o = 1'b1;
        wb_way_o = first_way;
        if (pend_empty) begin
          wb_req_o = 1'b0;
          state_d  = ST_WR;
        end else if (wb_gnt_i) begin
          // A done coincident with the grant retires the way without a wait cycle.
          if (wb_done_i) begin
            pending_d = pend_left;
            state_d   = |pend_left ? ST_WB_REQ : ST_WR;
          end else begin
            state_d = ST_WB_WAIT;
          end
        end
      end
      ST_WB_WAIT: begin
        wb_way_o = first_way;
        if (wb_done_i) begin
          pending_d = pend_left;
          state_d   = |pend_left ? ST_WB_REQ : ST_WR;
        end
      end
      ST_WR: begin
        vld_req_o    = 1'b1;
        vld_we_o     = 1'b1;
        vld_wvalid_o = (mode_q == MODE_CLEAN) ? valid_q : '0;
        if (vld_gnt_i) begin
          if (index_q == IDX_W'(NUM_SETS - 1)) state_d = ST_ACK;
          else begin
            index_d = index_q + 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_ACK: begin
        ack_o   = mask_q;
        index_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign vld_index_o = index_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_WB_INV;
      index_q   <= '0;
      pending_q <= '0;
      valid_q   <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      index_q   <= index_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      mask_q    <= mask_d;
    end
  end

endmodule
